// File: rtl/msp430_pkg.sv
// Shared encodings for the MSP430 instruction-cycle sequencer: address selects,
// sequencer states, opcode constants and decoded instruction classes.
package msp430_pkg;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned MAB_W   = 3;
    localparam int unsigned STATE_W = 4;

    // Memory address bus source selects
    localparam logic [MAB_W-1:0] MAB_PC  = 3'd0;
    localparam logic [MAB_W-1:0] MAB_SRC = 3'd1;
    localparam logic [MAB_W-1:0] MAB_DST = 3'd2;
    localparam logic [MAB_W-1:0] MAB_SP  = 3'd3;
    localparam logic [MAB_W-1:0] MAB_VEC = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_VEC_RD  = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_SRC_EXT = 4'd3,
        ST_SRC_RD  = 4'd4,
        ST_DST_EXT = 4'd5,
        ST_DST_RD  = 4'd6,
        ST_EXEC    = 4'd7,
        ST_DST_WR  = 4'd8,
        ST_PUSH_WR = 4'd9,
        ST_JMP_LD  = 4'd10
    } state_e;

    localparam logic [3:0] OP_MOV = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_BIT = 4'hB;

    localparam logic [2:0] F2_SXT  = 3'd3;
    localparam logic [2:0] F2_PUSH = 3'd4;
    localparam logic [2:0] F2_CALL = 3'd5;
    localparam logic [2:0] F2_RETI = 3'd6;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_JUMP    = 2'd1,
        CLS_FMT1    = 2'd2,
        CLS_FMT2    = 2'd3
    } ir_class_e;

    // Source operand access pattern after constant-generator folding
    typedef enum logic [2:0] {
        SM_REG = 3'd0,
        SM_IDX = 3'd1,
        SM_IMM = 3'd2,
        SM_IND = 3'd3,
        SM_INC = 3'd4
    } src_mode_e;

endpackage

// File: rtl/ir_classify.sv
// Combinational decode of the latched instruction register into the class and
// operand-mode fields that steer the sequencer.
module ir_classify
    import msp430_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output ir_class_e       cls,
    output src_mode_e       src_mode,
    output logic            dst_mode,
    output logic            cg_flag,
    output logic            no_write,
    output logic [2:0]      fmt2_op
);

    logic [3:0] opcode;
    logic [3:0] sreg;
    logic [1:0] as_f;
    logic       is_fmt2;
    logic       unused_bw;

    // Byte/word only matters to the datapath's increment size
    assign unused_bw = ir[6];

    always_comb begin
        opcode   = ir[15:12];
        as_f     = ir[5:4];
        fmt2_op  = ir[9:7];
        is_fmt2  = (ir[15:10] == 6'b000100);
        sreg     = is_fmt2 ? ir[3:0] : ir[11:8];
        cg_flag  = (sreg == 4'd3) || ((sreg == 4'd2) && as_f[1]);
        cls      = CLS_ILLEGAL;
        dst_mode = 1'b0;
        no_write = 1'b0;

        if (cg_flag) begin
            src_mode = SM_REG;
        end else begin
            case (as_f)
                2'b01:   src_mode = SM_IDX;
                2'b10:   src_mode = SM_IND;
                2'b11:   src_mode = (sreg == 4'd0) ? SM_IMM : SM_INC;
                default: src_mode = SM_REG;
            endcase
        end

        if (ir[15:13] == 3'b001) begin
            cls = CLS_JUMP;
        end else if (is_fmt2) begin
            cls = (fmt2_op >= F2_RETI) ? CLS_ILLEGAL : CLS_FMT2;
        end else if (opcode >= OP_MOV) begin
            cls      = CLS_FMT1;
            dst_mode = ir[7];
            no_write = (opcode == OP_CMP) || (opcode == OP_BIT);
        end
    end

endmodule

// File: rtl/mab_sequencer.sv
// MSP430 instruction-cycle controller: steps one instruction at a time through
// fetch, operand access, execute and write-back, driving MAB_SEL and strobes.
module mab_sequencer
    import msp430_pkg::*;
#(
    parameter bit WAIT_OK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IR_W-1:0]    ir,
    input  logic               mem_ready,
    output logic [MAB_W-1:0]   MAB_SEL,
    output logic               ir_load,
    output logic               ext_load,
    output logic               src_load,
    output logic               dst_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               sp_dec,
    output logic               src_autoinc,
    output logic               mem_write,
    output logic               mdb_pc_sel,
    output logic               reg_we,
    output logic               alu_go,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_e     state;
    state_e     state_nxt;
    state_e     src_entry;
    state_e     after_src;
    ir_class_e  cls;
    src_mode_e  src_mode;
    logic       dst_mode;
    logic       cg_flag;
    logic       no_write;
    logic [2:0] fmt2_op;
    logic       ready;
    logic       is_mov;
    logic       is_call;
    logic       is_stack;
    logic       f2_rmw;

    ir_classify u_classify (
        .ir       (ir),
        .cls      (cls),
        .src_mode (src_mode),
        .dst_mode (dst_mode),
        .cg_flag  (cg_flag),
        .no_write (no_write),
        .fmt2_op  (fmt2_op)
    );

    // Routing helpers shared by several states
    always_comb begin
        ready    = mem_ready | ~WAIT_OK;
        is_mov   = (cls == CLS_FMT1) && (ir[15:12] == OP_MOV);
        is_call  = (cls == CLS_FMT2) && (fmt2_op == F2_CALL);
        is_stack = (cls == CLS_FMT2) && ((fmt2_op == F2_PUSH) || (fmt2_op == F2_CALL));
        f2_rmw   = (cls == CLS_FMT2) && (fmt2_op <= F2_SXT) &&
                   (src_mode inside {SM_IDX, SM_IND, SM_INC});
        after_src = ((cls == CLS_FMT1) && dst_mode) ? ST_DST_EXT : ST_EXEC;
        case (src_mode)
            SM_IDX, SM_IMM: src_entry = ST_SRC_EXT;
            SM_IND, SM_INC: src_entry = f2_rmw ? ST_DST_RD : ST_SRC_RD;
            default:        src_entry = after_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_VEC_RD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        MAB_SEL     = MAB_PC;
        ir_load     = 1'b0;
        ext_load    = 1'b0;
        src_load    = 1'b0;
        dst_load    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        sp_dec      = 1'b0;
        src_autoinc = 1'b0;
        mem_write   = 1'b0;
        mdb_pc_sel  = 1'b0;
        reg_we      = 1'b0;
        alu_go      = 1'b0;
        illegal     = 1'b0;

        case (state)
            ST_VEC_RD: begin
                MAB_SEL = MAB_VEC;
                if (ready) begin
                    pc_load   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ready) begin
                    ir_load   = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_JUMP:           state_nxt = ST_EXEC;
                    CLS_FMT1, CLS_FMT2: state_nxt = src_entry;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                endcase
            end
            ST_SRC_EXT: begin
                if (ready) begin
                    pc_inc = 1'b1;
                    if (src_mode == SM_IMM) begin
                        src_load  = 1'b1;
                        state_nxt = after_src;
                    end else begin
                        ext_load  = 1'b1;
                        state_nxt = f2_rmw ? ST_DST_RD : ST_SRC_RD;
                    end
                end
            end
            ST_SRC_RD: begin
                MAB_SEL = MAB_SRC;
                if (ready) begin
                    src_load    = 1'b1;
                    src_autoinc = (src_mode == SM_INC);
                    state_nxt   = after_src;
                end
            end
            ST_DST_EXT: begin
                if (ready) begin
                    pc_inc    = 1'b1;
                    ext_load  = 1'b1;
                    state_nxt = is_mov ? ST_EXEC : ST_DST_RD;
                end
            end
            ST_DST_RD: begin
                // Single-operand read-modify-write reuses the source address
                MAB_SEL = f2_rmw ? MAB_SRC : MAB_DST;
                if (ready) begin
                    dst_load    = 1'b1;
                    src_autoinc = f2_rmw && (src_mode == SM_INC);
                    state_nxt   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                if (cls == CLS_JUMP) begin
                    alu_go  = 1'b1;
                    pc_load = 1'b1;
                end else if (is_stack) begin
                    sp_dec    = 1'b1;
                    state_nxt = ST_PUSH_WR;
                end else if (cls == CLS_FMT2) begin
                    alu_go = 1'b1;
                    reg_we = (src_mode == SM_REG) && !cg_flag;
                    if (f2_rmw) begin
                        state_nxt = ST_DST_WR;
                    end
                end else if (cls == CLS_FMT1) begin
                    alu_go = 1'b1;
                    if (!dst_mode) begin
                        reg_we = !no_write;
                    end else if (!no_write) begin
                        state_nxt = ST_DST_WR;
                    end
                end
            end
            ST_DST_WR: begin
                MAB_SEL = f2_rmw ? MAB_SRC : MAB_DST;
                if (ready) begin
                    mem_write = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_PUSH_WR: begin
                MAB_SEL = MAB_SP;
                if (ready) begin
                    mem_write  = 1'b1;
                    mdb_pc_sel = is_call;
                    state_nxt  = is_call ? ST_JMP_LD : ST_FETCH;
                end
            end
            ST_JMP_LD: begin
                pc_load   = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_VEC_RD;
        endcase

        // Reset abandons the instruction with no side effects this cycle
        if (!rst) begin
            MAB_SEL     = MAB_VEC;
            ir_load     = 1'b0;
            ext_load    = 1'b0;
            src_load    = 1'b0;
            dst_load    = 1'b0;
            pc_inc      = 1'b0;
            pc_load     = 1'b0;
            sp_dec      = 1'b0;
            src_autoinc = 1'b0;
            mem_write   = 1'b0;
            mdb_pc_sel  = 1'b0;
            reg_we      = 1'b0;
            alu_go      = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: doc/mab_sequencer.md
Name: mab_sequencer

Overview:
- Instruction-cycle controller for the MSP430 `pipeline` datapath.
- Per cycle it drives `MAB_SEL` to the datapath and issues load/strobe controls that step one instruction through fetch, operand access, execute and write-back.
- Decodes Format I, Format II and jump instructions from the latched instruction register, including constant-generator and addressing-mode corner cases.
- Sits beside `pipeline` in the core top level; `MAB_SEL` connects directly to `pipeline.MAB_SEL`.

Parameters:
- `WAIT_OK`, 1: when 1, honour `mem_ready` wait states; when 0, treat `mem_ready` as constant 1.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `ir`  in  16  latched instruction register from datapath; valid from the cycle after `ir_load`.
- `mem_ready`  in  1  memory access completes this cycle.
- `MAB_SEL`  out  3  address source: 0 PC, 1 SRC_ADDR (`CALC_OUT`), 2 DST_ADDR, 3 SP, 4 RST_VEC.
- `ir_load`  out  1  latch `MDB` into IR.
- `ext_load`  out  1  latch extension word.
- `src_load`  out  1  latch source operand.
- `dst_load`  out  1  latch destination operand.
- `pc_inc`  out  1  PC += 2.
- `pc_load`  out  1  load PC (reset vector, CALL target, jump target).
- `sp_dec`  out  1  SP -= 2.
- `src_autoinc`  out  1  Rsrc += 2 (or += 1 when B/W = 1).
- `mem_write`  out  1  write `MDB_out` to memory.
- `mdb_pc_sel`  out  1  `MDB_out` = PC (CALL) instead of ALU result.
- `reg_we`  out  1  write result to destination register.
- `alu_go`  out  1  ALU/flag update this cycle.
- `illegal`  out  1  one-cycle pulse: unsupported opcode.
- `state_o`  out  4  current state (debug).

Behaviour:
- Reset: while `rst` = 0 at a clock edge, state ← VEC_RD. All strobes are 0 and `MAB_SEL` = 4 during reset.
- Memory states: VEC_RD, FETCH, SRC_EXT, SRC_RD, DST_EXT, DST_RD, DST_WR, PUSH_WR.
  - Each holds until `mem_ready` = 1.
  - `MAB_SEL` stays stable while waiting.
  - Strobes assert only in the `mem_ready` cycle, so every strobe is a single-cycle pulse.
- VEC_RD: `MAB_SEL` 4, `pc_load` → FETCH.
- FETCH: `MAB_SEL` 0, `ir_load`, `pc_inc` → DECODE.
- DECODE (no memory access): classify `ir`.
  - Jump when `ir[15:13]` = 001.
  - Format II when `ir[15:10]` = 000100.
  - Format I when `ir[15:12]` ≥ 4.
  - Anything else: pulse `illegal` → FETCH.
- Format I fields: As = `ir[5:4]`, Ad = `ir[7]`, Rs = `ir[11:8]`.
  - Constant generator (no memory source): Rs = 3, or Rs = 2 with As ∈ {10, 11}.
  - Source path, first match wins:
    - Register or CG source: skip to destination path.
    - As = 01: SRC_EXT (`MAB_SEL` 0, `pc_inc`, `ext_load`) → SRC_RD (`MAB_SEL` 1, `src_load`).
    - As = 11, Rs = 0 (immediate): SRC_EXT with `src_load` instead of `ext_load`; no SRC_RD.
    - As = 10: SRC_RD.
    - As = 11, Rs ≠ 0: SRC_RD with `src_autoinc`.
  - Destination path:
    - Ad = 0: EXEC (`alu_go`, `reg_we` unless opcode CMP(9)/BIT(B)) → FETCH.
    - Ad = 1: DST_EXT (`MAB_SEL` 0, `pc_inc`, `ext_load`) → DST_RD (`MAB_SEL` 2, `dst_load`; skipped for MOV(4)) → EXEC (`alu_go`) → DST_WR (`MAB_SEL` 2, `mem_write`; skipped for CMP/BIT) → FETCH.
- Format II (opc = `ir[9:7]`): source operand as above, using Rd = `ir[3:0]`.
  - RRC/SWPB/RRA/SXT (0–3):
    - Register operand: EXEC with `reg_we`.
    - Memory operand: DST_RD (`MAB_SEL` 1 reused as operand address) → EXEC → DST_WR.
  - PUSH (4): EXEC (`sp_dec`) → PUSH_WR (`MAB_SEL` 3, `mem_write`).
  - CALL (5): EXEC (`sp_dec`) → PUSH_WR (`MAB_SEL` 3, `mem_write`, `mdb_pc_sel`) → JMP_LD (`pc_load`) → FETCH.
  - RETI (6) and opc 7: `illegal` pulse → FETCH.
- Jump: EXEC (`alu_go`, `pc_load` gated externally by condition) → FETCH.
- Cycle counts (zero wait), FETCH to next FETCH: MOV Rs,Rd = 3; CMP #imm,Rd = 4; ADD @Rs+,x(Rd) = 7; PUSH Rs = 4.
- Reset asserted mid-instruction: abandon at once; no strobe issued in the reset cycle.

Decomposition:
- Package `msp430_pkg`:
  - `MAB_SEL` encoding constants.
  - State enum (4 bits).
  - Opcode constants: MOV/CMP/BIT, Format II opc.
  - Instruction-class localparams.
- One sub-module, `ir_classify`: combinational decode of `ir` into class, src_mode, dst_mode, cg_flag, no_write and fmt2_op.

Test Plan:
- Reset: `rst` = 0 for 2 cycles, then release, `mem_ready` = 1 → `MAB_SEL` = 4 with `pc_load` in the first cycle, then FETCH with `MAB_SEL` = 0, `ir_load` and `pc_inc`.
- `ir` = 0x4506 (MOV R5,R6) → FETCH, DECODE, EXEC; `reg_we` = 1 in EXEC; no `src_load`.
- `ir` = 0x55B6 (ADD @R5+,0(R6)) → SRC_RD with `src_autoinc`, DST_EXT, DST_RD, EXEC, DST_WR with `MAB_SEL` = 2 and `mem_write`; 7 cycles total.
- `ir` = 0x9037 (CMP #imm,R7) → SRC_EXT with `src_load` and `pc_inc`; EXEC with `alu_go` = 1 and `reg_we` = 0. Also `ir` = 0x4314 (MOV #1,R4, CG) → no memory cycle.
- `ir` = 0x12B0 (CALL #imm) with `mem_ready` low for 2 cycles in PUSH_WR → `MAB_SEL` = 3 held for 3 cycles; `mem_write` and `mdb_pc_sel` pulse once; then `pc_load`.
- `rst` low during DST_RD of 0x55B6 → next state VEC_RD; no `dst_load` or `mem_write` emitted. Also `ir` = 0x1300 (RETI) → `illegal` pulses for 1 cycle, then FETCH.
